// File: rtl/branch_operand_hazard_unit.sv
// Decode-stage hazard detection and operand forwarding for the branch
// comparator. A shadow pipeline of {dest reg, Tnew} entries for E/M/W is
// kept locally and compared against the D-stage sources each cycle.
module branch_operand_hazard_unit #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [1:0]    d_tuse_rs,
  input  logic [1:0]    d_tuse_rt,
  input  logic [4:0]    d_wa,
  input  logic [1:0]    d_tnew,
  input  logic [DW-1:0] grf_rd1,
  input  logic [DW-1:0] grf_rd2,
  input  logic [DW-1:0] e_fwd_data,
  input  logic [DW-1:0] m_fwd_data,
  input  logic [DW-1:0] w_fwd_data,
  output logic          stall,
  output logic [DW-1:0] cmp1,
  output logic [DW-1:0] cmp2
);

  logic [4:0] e_wa_q, e_wa_d, m_wa_q, m_wa_d, w_wa_q, w_wa_d;
  logic [1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;

  logic          rs_hit, rt_hit;
  logic [1:0]    rs_tnew, rt_tnew;
  logic [DW-1:0] rs_fwd, rt_fwd;
  logic          rs_haz, rt_haz;

  function automatic logic [1:0] dec_sat(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  // Resolve the youngest matching in-flight producer for rs (E > M > W)
  always_comb begin
    rs_hit  = 1'b0;
    rs_tnew = '0;
    rs_fwd  = grf_rd1;
    if (d_rs != 5'd0) begin
      if (d_rs == e_wa_q) begin
        rs_hit  = 1'b1;
        rs_tnew = e_tnew_q;
        rs_fwd  = e_fwd_data;
      end else if (d_rs == m_wa_q) begin
        rs_hit  = 1'b1;
        rs_tnew = m_tnew_q;
        rs_fwd  = m_fwd_data;
      end else if (d_rs == w_wa_q) begin
        rs_hit  = 1'b1;
        rs_tnew = w_tnew_q;
        rs_fwd  = w_fwd_data;
      end
    end
  end

  // Resolve the youngest matching in-flight producer for rt (E > M > W)
  always_comb begin
    rt_hit  = 1'b0;
    rt_tnew = '0;
    rt_fwd  = grf_rd2;
    if (d_rt != 5'd0) begin
      if (d_rt == e_wa_q) begin
        rt_hit  = 1'b1;
        rt_tnew = e_tnew_q;
        rt_fwd  = e_fwd_data;
      end else if (d_rt == m_wa_q) begin
        rt_hit  = 1'b1;
        rt_tnew = m_tnew_q;
        rt_fwd  = m_fwd_data;
      end else if (d_rt == w_wa_q) begin
        rt_hit  = 1'b1;
        rt_tnew = w_tnew_q;
        rt_fwd  = w_fwd_data;
      end
    end
  end

  // Stall when the winning producer is not ready by the consumer's use
  // cycle; forward only once the winner's result is already available.
  always_comb begin
    rs_haz = rs_hit && (rs_tnew > d_tuse_rs);
    rt_haz = rt_hit && (rt_tnew > d_tuse_rt);
    stall  = rs_haz || rt_haz;
    cmp1   = (rs_hit && (rs_tnew == 2'd0)) ? rs_fwd : grf_rd1;
    cmp2   = (rt_hit && (rt_tnew == 2'd0)) ? rt_fwd : grf_rd2;
  end

  // Shadow pipeline advance; a stall injects a bubble into E only
  always_comb begin
    e_wa_d   = stall ? 5'd0 : d_wa;
    e_tnew_d = stall ? 2'd0 : d_tnew;
    m_wa_d   = e_wa_q;
    m_tnew_d = dec_sat(e_tnew_q);
    w_wa_d   = m_wa_q;
    w_tnew_d = dec_sat(m_tnew_q);
  end

  // Shadow pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_wa_q   <= '0;
      e_tnew_q <= '0;
      m_wa_q   <= '0;
      m_tnew_q <= '0;
      w_wa_q   <= '0;
      w_tnew_q <= '0;
    end else begin
      e_wa_q   <= e_wa_d;
      e_tnew_q <= e_tnew_d;
      m_wa_q   <= m_wa_d;
      m_tnew_q <= m_tnew_d;
      w_wa_q   <= w_wa_d;
      w_tnew_q <= w_tnew_d;
    end
  end

endmodule

// File: tb/tb_branch_operand_hazard_unit.sv
// Scoreboard bench for branch_operand_hazard_unit: the driver applies
// directed D-stage vectors and queues hand-computed expectations; the
// monitor pops and compares on the falling edge (or on demand).
module tb_branch_operand_hazard_unit;

  localparam logic [31:0] G1 = 32'h1111_1111;
  localparam logic [31:0] G2 = 32'h2222_2222;
  localparam logic [31:0] ED = 32'hEEEE_0001;
  localparam logic [31:0] MD = 32'h0000_0005;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic [31:0] grf_rd1, grf_rd2, e_fwd_data, m_fwd_data, w_fwd_data;
  logic        stall;
  logic [31:0] cmp1, cmp2;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] c1;
    logic [31:0] c2;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  event chk_now;

  branch_operand_hazard_unit #(.DW(32)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew),
    .grf_rd1(grf_rd1), .grf_rd2(grf_rd2),
    .e_fwd_data(e_fwd_data), .m_fwd_data(m_fwd_data), .w_fwd_data(w_fwd_data),
    .stall(stall), .cmp1(cmp1), .cmp2(cmp2)
  );

  always #5 clk = ~clk;

  task automatic push(input string name, input logic es,
                      input logic [31:0] e1, input logic [31:0] e2);
    exp_t x;
    x.name = name; x.stall = es; x.c1 = e1; x.c2 = e2;
    q.push_back(x);
  endtask

  task automatic vec(input string name,
                     input logic [4:0] rs, input logic [1:0] tu_rs,
                     input logic [4:0] rt, input logic [1:0] tu_rt,
                     input logic [4:0] wa, input logic [1:0] tn,
                     input logic es, input logic [31:0] e1, input logic [31:0] e2);
    @(posedge clk);
    #1;
    d_rs = rs; d_tuse_rs = tu_rs;
    d_rt = rt; d_tuse_rt = tu_rt;
    d_wa = wa; d_tnew = tn;
    push(name, es, e1, e2);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) vec("idle", 0, 3, 0, 3, 0, 0, 1'b0, G1, G2);
  endtask

  // Monitor: compare every queued expectation against the live outputs
  initial begin
    exp_t x;
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0) begin
        x = q.pop_front();
        tests++;
        if (stall !== x.stall || cmp1 !== x.c1 || cmp2 !== x.c2) begin
          fails++;
          $display("FAIL %s: got stall=%0b cmp1=%h cmp2=%h, required stall=%0b cmp1=%h cmp2=%h",
                   x.name, stall, cmp1, cmp2, x.stall, x.c1, x.c2);
        end
      end
    end
  end

  // Driver
  initial begin
    int waited;
    reset = 1'b1;
    d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_wa = 0; d_tnew = 0;
    grf_rd1 = G1; grf_rd2 = G2;
    e_fwd_data = ED; m_fwd_data = MD; w_fwd_data = WD;

    @(posedge clk); #1;
    push("reset_state", 1'b0, G1, G2);
    @(posedge clk); #1;
    reset = 1'b0;
    flush();

    // load then branch on rs, tuse 0: two stalls then W forward
    vec("ld_issue",  0, 3, 0, 3, 1, 2, 1'b0, G1, G2);
    vec("ld_stall1", 1, 0, 0, 3, 0, 0, 1'b1, G1, G2);
    vec("ld_stall2", 1, 0, 0, 3, 0, 0, 1'b1, G1, G2);
    vec("ld_fwd_w",  1, 0, 0, 3, 0, 0, 1'b0, WD, G2);
    flush();

    // ALU then branch on rt, tuse 0: one stall then M forward
    vec("alu_issue", 0, 3, 0, 3, 3, 1, 1'b0, G1, G2);
    vec("alu_stall", 0, 3, 3, 0, 0, 0, 1'b1, G1, G2);
    vec("alu_fwd_m", 0, 3, 3, 0, 0, 0, 1'b0, G1, MD);
    flush();

    // ALU then consumer in E (tuse 1): no stall
    vec("alu1_issue", 0, 3, 0, 3, 5, 1, 1'b0, G1, G2);
    vec("alu_tuse1",  5, 1, 0, 3, 0, 0, 1'b0, G1, G2);
    flush();

    // load then consumer in E (tuse 1): one stall
    vec("ld1_issue",      0, 3, 0, 3, 6, 2, 1'b0, G1, G2);
    vec("ld_tuse1_stall", 0, 3, 6, 1, 0, 0, 1'b1, G1, G2);
    vec("ld_tuse1_go",    0, 3, 6, 1, 0, 0, 1'b0, G1, G2);
    flush();

    // jal then branch on $31: immediate E forward
    vec("jal_issue", 0, 3, 0, 3, 31, 0, 1'b0, G1, G2);
    vec("jal_fwd_e", 31, 0, 0, 3, 0, 0, 1'b0, ED, G2);
    flush();

    // $0 producer/consumer and unused source
    vec("r0_issue",     0, 3, 0, 3, 0, 2, 1'b0, G1, G2);
    vec("r0_consumer",  0, 0, 0, 0, 0, 0, 1'b0, G1, G2);
    vec("unused_issue", 0, 3, 0, 3, 7, 2, 1'b0, G1, G2);
    vec("unused_tuse3", 7, 3, 0, 3, 0, 0, 1'b0, G1, G2);
    flush();

    // both sources hazardous: ALU $9 then load $8, branch on $8/$9
    vec("both_alu",    0, 3, 0, 3, 9, 1, 1'b0, G1, G2);
    vec("both_ld",     0, 3, 0, 3, 8, 2, 1'b0, G1, G2);
    vec("both_stall1", 8, 0, 9, 0, 0, 0, 1'b1, G1, MD);
    vec("both_stall2", 8, 0, 9, 0, 0, 0, 1'b1, G1, WD);
    vec("both_go",     8, 0, 9, 0, 0, 0, 1'b0, WD, G2);
    flush();

    // priority: ALU $4 then load $4; the younger load decides
    vec("pri_alu",    0, 3, 0, 3, 4, 1, 1'b0, G1, G2);
    vec("pri_ld",     0, 3, 0, 3, 4, 2, 1'b0, G1, G2);
    vec("pri_stall1", 4, 0, 0, 3, 0, 0, 1'b1, G1, G2);
    vec("pri_stall2", 4, 0, 0, 3, 0, 0, 1'b1, G1, G2);
    vec("pri_go",     4, 0, 0, 3, 0, 0, 1'b0, WD, G2);
    flush();

    // reset during the first stall cycle of a load-use
    vec("rst_ld_issue", 0, 3, 0, 3, 1, 2, 1'b0, G1, G2);
    vec("rst_pre",      1, 0, 0, 3, 0, 0, 1'b1, G1, G2);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    push("rst_async", 1'b0, G1, G2);
    -> chk_now;
    @(posedge clk); #1;
    reset = 1'b0;
    push("rst_after", 1'b0, G1, G2);
    vec("rst_after2", 1, 0, 0, 3, 0, 0, 1'b0, G1, G2);
    vec("rst_idle",   0, 3, 0, 3, 0, 0, 1'b0, G1, G2);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_operand_hazard_unit.md
# branch_operand_hazard_unit

Decode-stage hazard and forwarding unit for the 5-stage pipelined MIPS core. It supplies the two 32-bit operands of the branch comparator with the freshest value of `rs`/`rt`. It asserts `stall` when a required value cannot be produced in time. It keeps its own shadow pipeline of in-flight destination registers and their remaining-latency (Tnew) counters for the E, M and W stages.

## Interface

Parameters:
- `DW`, default 32: data width of operands and forwarded results.

Ports:
- `clk`, in, 1: the single clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears the shadow pipeline.
- `d_rs`, in, 5: D-stage source register 1.
- `d_rt`, in, 5: D-stage source register 2.
- `d_tuse_rs`, in, 2: cycles until `rs` is consumed. 0 means branch compare in D, 1 means E, 3 means unused.
- `d_tuse_rt`, in, 2: same encoding, for `rt`.
- `d_wa`, in, 5: D-stage destination register; 0 means no write.
- `d_tnew`, in, 2: cycles after entering E until the result is forwardable. 0 means jal link, 1 means ALU, 2 means load.
- `grf_rd1`, in, DW: register file read data for `rs`.
- `grf_rd2`, in, DW: register file read data for `rt`.
- `e_fwd_data`, in, DW: forwardable result currently held in E.
- `m_fwd_data`, in, DW: forwardable result currently held in M.
- `w_fwd_data`, in, DW: forwardable result currently held in W.
- `stall`, out, 1: freeze PC and the F/D register, and inject a bubble into E.
- `cmp1`, out, DW: forwarded `rs` operand for the branch comparator.
- `cmp2`, out, DW: forwarded `rt` operand for the branch comparator.

## Operation

- Shadow state: three entries `E`, `M`, `W`, each `{wa[4:0], tnew[1:0]}`.
- Reset value of every entry is `{0,0}`. With all entries cleared, `stall`=0, `cmp1`=`grf_rd1` and `cmp2`=`grf_rd2`.
- Advance on each rising edge, with dec(x) = x-1 saturating at 0:
  - When `stall`=0: `E`←`{d_wa,d_tnew}`, `M`←`{E.wa,dec(E.tnew)}`, `W`←`{M.wa,dec(M.tnew)}`.
  - When `stall`=1: `E`←`{0,0}` (bubble); `M` and `W` advance exactly as above.
- Match rules, per source register `r` (`rs` or `rt`):
  - A stage matches when `wa`==`r` and `r`≠0. Register $0 never matches, never stalls and never forwards.
  - The youngest matching stage wins, in priority order E, then M, then W.
- Hazard rule, per source: stall when the winning stage has `tnew` > `tuse`.
  - `stall` = hazard(rs) OR hazard(rt).
  - `tuse`=3 never stalls, because `tnew` is at most 2.
- Forward rule, per source:
  - If the winning stage has `tnew`==0, output that stage's `*_fwd_data`.
  - Otherwise output the GRF value. In that case the operand is either stalled or forwarded downstream, so its D-stage value is don't-care.
- The GRF provides no write-through. A matching W entry is always forwarded from `w_fwd_data`.

## Timing

- `stall`, `cmp1` and `cmp2` are purely combinational from the current shadow state and the D-stage inputs, with no added latency. The branch decision happens in the same cycle.
- The shadow state updates only on `clk` rising edge. `reset` acts immediately and asynchronously.
- Stall length, for a producer immediately followed by a consumer with `tuse`=0:
  - Load (`tnew`=2): 2 cycles.
  - ALU (`tnew`=1): 1 cycle.
  - jal (`tnew`=0): 0 cycles.
- Same condition with consumer `tuse`=1: load stalls 1 cycle; ALU stalls 0 cycles.
- Simultaneous matches: if E and M both write `r`, E decides both stall and forward, even when M has `tnew`=0.
- Both sources hazardous: a single `stall` is asserted for the longer of the two requirements.
- Reset mid-stall: all entries clear. `stall` deasserts combinationally and stays 0 until new producers are issued.

## Test plan

- Load then branch: issue `d_wa`=1, `d_tnew`=2; next D has `d_rs`=1, `d_tuse_rs`=0.
  - Required: `stall`=1 for 2 cycles.
  - Third cycle: `stall`=0 and `cmp1`=`w_fwd_data` (drive 0xDEADBEEF, expect 0xDEADBEEF).
- ALU then branch: `d_wa`=3, `d_tnew`=1; next D has `d_rt`=3, `d_tuse_rt`=0.
  - Required: 1 stall cycle, then `cmp2`=`m_fwd_data` (0x00000005).
- jal then branch on $31: `d_tnew`=0.
  - Required: no stall; `cmp1`=`e_fwd_data` in the very next cycle.
- $0 and unused sources: producer writes `wa`=0, or consumer uses `rs`=0 or `tuse`=3.
  - Required: `stall`=0 and `cmp1`=`grf_rd1` throughout.
- Priority: ALU writes $4, then load writes $4, then branch reads $4.
  - Required: stall driven by the E load entry for 2 cycles.
  - Operand is never taken from the older M entry.
- Reset mid-operation: assert `reset` during the first stall cycle of the load case.
  - Required: `stall`=0 immediately.
  - After release, the branch sees `cmp1`=`grf_rd1` and no stall.
